// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM.
// Sequences fetch, decode, execute, memory access and writeback, and drives
// the datapath selects, write enables and the 4-bit ALU operation code
// (0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR).
// Ports:
//   clock, reset (async, active-low)          - clock and reset
//   opcode, funct                             - instruction fields from the IR
//   zero                                      - ALU zero flag, resolves beq
//   unidadeControle                           - ALU operation code
//   escrevePC, pcFonte, IouD, leMem,
//   escreveMem, escreveIR, memParaReg,
//   regDst, escreveReg, aluSrcA, aluSrcB      - datapath controls
//   estado                                    - current state (debug)
//   invalida                                  - sticky illegal-instruction flag
//   contaInstrucoes                           - retired-instruction counter
module controle_multiciclo #(
  parameter int unsigned LARGURA_CONTADOR = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [5:0]                  opcode,
  input  logic [5:0]                  funct,
  input  logic                        zero,
  output logic [3:0]                  unidadeControle,
  output logic                        escrevePC,
  output logic [1:0]                  pcFonte,
  output logic                        IouD,
  output logic                        leMem,
  output logic                        escreveMem,
  output logic                        escreveIR,
  output logic                        memParaReg,
  output logic                        regDst,
  output logic                        escreveReg,
  output logic                        aluSrcA,
  output logic [1:0]                  aluSrcB,
  output logic [3:0]                  estado,
  output logic                        invalida,
  output logic [LARGURA_CONTADOR-1:0] contaInstrucoes
);

  typedef enum logic [3:0] {
    StBusca  = 4'd0,
    StDecod  = 4'd1,
    StEndMem = 4'd2,
    StLeMem  = 4'd3,
    StEscrLw = 4'd4,
    StEscrSw = 4'd5,
    StExecR  = 4'd6,
    StEscrR  = 4'd7,
    StDesvio = 4'd8,
    StSalto  = 4'd9,
    StExecI  = 4'd10,
    StEscrI  = 4'd11,
    StErro   = 4'd12,
    StInicio = 4'd15
  } estado_e;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpAddi = 6'h08;

  estado_e                     estado_q, estado_d;
  logic                        invalida_q;
  logic [LARGURA_CONTADOR-1:0] conta_q, conta_d;
  logic [3:0]                  alu_funct;
  logic                        funct_ok;
  logic                        retira;

  // R-type funct decode; unknown functs still present ADD to the ALU.
  always_comb begin
    alu_funct = 4'd2;
    funct_ok  = 1'b1;
    case (funct)
      6'h20:   alu_funct = 4'd2;
      6'h22:   alu_funct = 4'd3;
      6'h24:   alu_funct = 4'd0;
      6'h25:   alu_funct = 4'd1;
      6'h2A:   alu_funct = 4'd4;
      6'h27:   alu_funct = 4'd5;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Every final state of an instruction returns to BUSCA, so leaving one retires it.
  always_comb begin
    retira  = (estado_q == StEscrR)  || (estado_q == StEscrLw) || (estado_q == StEscrSw) ||
              (estado_q == StDesvio) || (estado_q == StSalto)  || (estado_q == StEscrI);
    conta_d = retira ? conta_q + LARGURA_CONTADOR'(1) : conta_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= StInicio;
      conta_q    <= '0;
      invalida_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      conta_q    <= conta_d;
      invalida_q <= invalida_q | (estado_d == StErro);
    end
  end

  always_comb begin
    estado_d = StBusca;
    case (estado_q)
      StInicio: estado_d = StBusca;
      StBusca:  estado_d = StDecod;
      StDecod: begin
        case (opcode)
          OpR:         estado_d = StExecR;
          OpLw, OpSw:  estado_d = StEndMem;
          OpBeq:       estado_d = StDesvio;
          OpJ:         estado_d = StSalto;
          OpAddi:      estado_d = StExecI;
          default:     estado_d = StErro;
        endcase
      end
      StExecR:  estado_d = funct_ok ? StEscrR : StErro;
      // Opcode is required stable; a change here is treated as illegal.
      StEndMem: estado_d = (opcode == OpLw) ? StLeMem :
                           (opcode == OpSw) ? StEscrSw : StErro;
      StLeMem:  estado_d = StEscrLw;
      StExecI:  estado_d = StEscrI;
      StErro:   estado_d = StErro;
      default:  estado_d = StBusca;  // final states and unused encodings
    endcase
  end

  always_comb begin
    unidadeControle = 4'd0;
    escrevePC       = 1'b0;
    pcFonte         = 2'd0;
    IouD            = 1'b0;
    leMem           = 1'b0;
    escreveMem      = 1'b0;
    escreveIR       = 1'b0;
    memParaReg      = 1'b0;
    regDst          = 1'b0;
    escreveReg      = 1'b0;
    aluSrcA         = 1'b0;
    aluSrcB         = 2'd0;
    case (estado_q)
      StBusca: begin
        leMem           = 1'b1;
        escreveIR       = 1'b1;
        aluSrcB         = 2'd1;
        unidadeControle = 4'd2;
        escrevePC       = 1'b1;
      end
      StDecod: begin
        aluSrcB         = 2'd3;
        unidadeControle = 4'd2;
      end
      StExecR: begin
        aluSrcA         = 1'b1;
        unidadeControle = alu_funct;
      end
      StEscrR: begin
        regDst     = 1'b1;
        escreveReg = 1'b1;
      end
      StEndMem, StExecI: begin
        aluSrcA         = 1'b1;
        aluSrcB         = 2'd2;
        unidadeControle = 4'd2;
      end
      StLeMem: begin
        leMem = 1'b1;
        IouD  = 1'b1;
      end
      StEscrLw: begin
        memParaReg = 1'b1;
        escreveReg = 1'b1;
      end
      StEscrSw: begin
        escreveMem = 1'b1;
        IouD       = 1'b1;
      end
      StDesvio: begin
        aluSrcA         = 1'b1;
        unidadeControle = 4'd3;
        pcFonte         = 2'd1;
        escrevePC       = zero;
      end
      StSalto: begin
        pcFonte   = 2'd2;
        escrevePC = 1'b1;
      end
      StEscrI: escreveReg = 1'b1;
      default: ;
    endcase
  end

  assign estado          = estado_q;
  assign invalida        = invalida_q;
  assign contaInstrucoes = conta_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;

  logic [3:0]  alu_m, est_m, alu_w, est_w;
  logic        wpc_m, iod_m, lm_m, wm_m, wir_m, m2r_m, rd_m, wr_m, asa_m, inv_m;
  logic        wpc_w, iod_w, lm_w, wm_w, wir_w, m2r_w, rd_w, wr_w, asa_w, inv_w;
  logic [1:0]  pcf_m, asb_m, pcf_w, asb_w;
  logic [31:0] cnt_m;
  logic [2:0]  cnt_w;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cnt_exp = '0;

  always #5 clock = ~clock;

  controle_multiciclo #(.LARGURA_CONTADOR(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .unidadeControle(alu_m), .escrevePC(wpc_m), .pcFonte(pcf_m), .IouD(iod_m),
    .leMem(lm_m), .escreveMem(wm_m), .escreveIR(wir_m), .memParaReg(m2r_m),
    .regDst(rd_m), .escreveReg(wr_m), .aluSrcA(asa_m), .aluSrcB(asb_m),
    .estado(est_m), .invalida(inv_m), .contaInstrucoes(cnt_m)
  );

  // Narrow counter copy so that wrap from all-ones to zero is exercised.
  controle_multiciclo #(.LARGURA_CONTADOR(3)) dut_w (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .unidadeControle(alu_w), .escrevePC(wpc_w), .pcFonte(pcf_w), .IouD(iod_w),
    .leMem(lm_w), .escreveMem(wm_w), .escreveIR(wir_w), .memParaReg(m2r_w),
    .regDst(rd_w), .escreveReg(wr_w), .aluSrcA(asa_w), .aluSrcB(asb_w),
    .estado(est_w), .invalida(inv_w), .contaInstrucoes(cnt_w)
  );

  wire [12:0] ctrl_m = {wpc_m, pcf_m, iod_m, lm_m, wm_m, wir_m, m2r_m, rd_m, wr_m, asa_m, asb_m};
  wire [12:0] ctrl_w = {wpc_w, pcf_w, iod_w, lm_w, wm_w, wir_w, m2r_w, rd_w, wr_w, asa_w, asb_w};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h20: return 4'd2;
      6'h22: return 4'd3;
      6'h2A: return 4'd4;
      6'h27: return 4'd5;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
  endfunction

  // Expected {alu[3:0], escrevePC, pcFonte, IouD, leMem, escreveMem, escreveIR,
  // memParaReg, regDst, escreveReg, aluSrcA, aluSrcB} for a state number.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] fn, input logic z);
    logic [3:0] alu = '0;
    logic wpc = 0, iod = 0, lm = 0, wm = 0, wir = 0, m2r = 0, rd = 0, wr = 0, asa = 0;
    logic [1:0] pcf = '0, asb = '0;
    case (st)
      0:  begin lm = 1; wir = 1; asb = 2'd1; alu = 4'd2; wpc = 1; end
      1:  begin asb = 2'd3; alu = 4'd2; end
      2:  begin asa = 1; asb = 2'd2; alu = 4'd2; end
      3:  begin lm = 1; iod = 1; end
      4:  begin m2r = 1; wr = 1; end
      5:  begin wm = 1; iod = 1; end
      6:  begin asa = 1; alu = alu_of_funct(fn); end
      7:  begin rd = 1; wr = 1; end
      8:  begin asa = 1; alu = 4'd3; pcf = 2'd1; wpc = z; end
      9:  begin pcf = 2'd2; wpc = 1; end
      10: begin asa = 1; asb = 2'd2; alu = 4'd2; end
      11: wr = 1;
      default: ;
    endcase
    return {alu, wpc, pcf, iod, lm, wm, wir, m2r, rd, wr, asa, asb};
  endfunction

  task automatic check_cycle(input int st, input logic [5:0] fn);
    logic [16:0] e;
    e = exp_ctrl(st, fn, zero);
    chk("estado", 32'(est_m), 32'(st));
    chk("unidadeControle", 32'(alu_m), 32'(e[16:13]));
    chk("controls", 32'(ctrl_m), 32'(e[12:0]));
    chk("invalida", 32'(inv_m), 32'(st == 12));
    chk("contaInstrucoes", cnt_m, cnt_exp);
    chk("estado_w", 32'(est_w), 32'(st));
    chk("controls_w", 32'({alu_w, ctrl_w}), 32'(e));
    chk("conta_wrap", 32'(cnt_w), 32'(cnt_exp[2:0]));
  endtask

  // Reset asserted away from a clock edge; released on a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    cnt_exp = '0;
    check_cycle(15, funct);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_cycle(15, funct);
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction from BUSCA. zmode: 0/1 fixed zero, 2 random each cycle.
  // abort_at: state in which reset is pulled low asynchronously (-1 for none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int abort_at);
    int path[$];
    path = '{0, 1};
    case (op)
      6'h00: if (funct_legal(fn)) path.push_back(6); else path.push_back(6);
      default: ;
    endcase
    case (op)
      6'h00: path.push_back(funct_legal(fn) ? 7 : 12);
      6'h23: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'h2B: begin path.push_back(2); path.push_back(5); end
      6'h04: path.push_back(8);
      6'h02: path.push_back(9);
      6'h08: begin path.push_back(10); path.push_back(11); end
      default: path.push_back(12);
    endcase
    opcode = op;
    funct  = fn;
    foreach (path[i]) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1;
      check_cycle(path[i], fn);
      if (path[i] == abort_at) begin
        reset = 1'b0;
        #1;
        cnt_exp = '0;
        check_cycle(15, fn);
        return;
      end
      if (path[i] != 12) begin
        @(posedge clock);
        #1;
        if (i == path.size() - 1) cnt_exp = cnt_exp + 32'd1;
      end
    end
  endtask

  initial begin
    logic [5:0] ops[6]    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    logic [5:0] functs[6] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};

    #1;
    do_reset();

    run_instr(6'h00, 6'h20, 2, -1);
    foreach (functs[k]) run_instr(6'h00, functs[k], 2, -1);

    run_instr(6'h00, 6'h00, 2, -1);
    for (int c = 0; c < 11; c++) begin
      @(posedge clock);
      #1;
      check_cycle(12, funct);
    end
    do_reset();

    run_instr(6'h23, 6'h15, 2, -1);
    run_instr(6'h2B, 6'h3C, 2, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h02, 6'h11, 2, -1);
    run_instr(6'h08, 6'h2A, 2, -1);

    run_instr(6'h3F, 6'h20, 2, -1);
    @(posedge clock);
    #1;
    check_cycle(12, funct);
    do_reset();

    run_instr(6'h00, 6'h22, 2, -1);
    run_instr(6'h23, 6'h00, 2, 3);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 5)], functs[$urandom_range(0, 5)], 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
